// File: rtl/me_window_loader.sv
// Ping-pong reference/search window loader for the motion-estimation engine.
// Streams one block into the write bank while the engine searches the other one.
module me_window_loader #(
    parameter int R_PIXELS = 256,
    parameter int S_PIXELS = 1024,
    parameter int CNT_W    = 11
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        pix_valid,
    input  logic [7:0]                  pix_data,
    output logic                        pix_ready,
    input  logic [$clog2(R_PIXELS)-1:0] AddressR,
    input  logic [$clog2(S_PIXELS)-1:0] AddressS1,
    input  logic [$clog2(S_PIXELS)-1:0] AddressS2,
    output logic [7:0]                  R,
    output logic [7:0]                  S1,
    output logic [7:0]                  S2,
    output logic                        start,
    input  logic                        completed,
    output logic                        busy,
    output logic [15:0]                 block_count
);

    localparam int RA_W = $clog2(R_PIXELS);
    localparam int SA_W = $clog2(S_PIXELS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RELEASE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_bank_full;
    logic [1:0]        w_bank_full_next;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [15:0]       r_block_count;

    logic [7:0]        r_rmem [2][R_PIXELS];
    logic [7:0]        r_smem [2][S_PIXELS];

    logic              w_accept;
    logic              w_is_r;
    logic              w_last;
    logic              w_fill_done;
    logic              w_start;
    logic              w_busy;
    logic              w_release;
    logic [RA_W-1:0]   w_r_addr;
    logic [SA_W-1:0]   w_s_addr;

    assign pix_ready   = !r_bank_full[r_wr_bank];
    assign w_accept    = pix_valid && pix_ready;
    assign w_is_r      = r_wr_cnt < CNT_W'(R_PIXELS);
    assign w_last      = r_wr_cnt == CNT_W'(R_PIXELS + S_PIXELS - 1);
    assign w_fill_done = w_accept && w_last;
    assign w_r_addr    = RA_W'(r_wr_cnt);
    assign w_s_addr    = SA_W'(r_wr_cnt - CNT_W'(R_PIXELS));

    // Run FSM: IDLE always lasts at least one cycle so the engine counter sees start low.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_busy       = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_start = 1'b1;
                w_busy  = 1'b1;
                if (completed) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_busy       = 1'b1;
                w_release    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Fill and release always touch different bank bits, so both may land on one edge.
    always_comb begin
        w_bank_full_next = r_bank_full;
        if (w_fill_done) begin
            w_bank_full_next[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_bank_full_next[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bank_full   <= 2'b00;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_cnt      <= '0;
            r_block_count <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            r_bank_full <= w_bank_full_next;
            if (w_accept) begin
                r_wr_cnt <= w_last ? '0 : r_wr_cnt + 1'b1;
            end
            if (w_fill_done) begin
                r_wr_bank <= !r_wr_bank;
            end
            if (w_release) begin
                r_rd_bank     <= !r_rd_bank;
                r_block_count <= r_block_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            if (w_is_r) begin
                r_rmem[r_wr_bank][w_r_addr] <= pix_data;
            end else begin
                r_smem[r_wr_bank][w_s_addr] <= pix_data;
            end
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            assert (!(w_fill_done && w_release && (r_wr_bank == r_rd_bank)));
        end
    end

    assign R           = r_rmem[r_rd_bank][AddressR];
    assign S1          = r_smem[r_rd_bank][AddressS1];
    assign S2          = r_smem[r_rd_bank][AddressS2];
    assign start       = w_start;
    assign busy        = w_busy;
    assign block_count = r_block_count;

endmodule
